// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between the instruction-fetch (read-only) side and the data side.
// Data side has priority; fetch wins after MAX_D_STREAK consecutive data grants, and a missing ack ends in an error completion.
module mem_arbiter #(
  parameter int WORD_LEN     = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic [WORD_LEN-1:0] i_rdata,
  output logic                i_valid,
  output logic                i_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata,
  input  logic                mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] MAX_S    = 4'(MAX_D_STREAK);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  logic                r_gnt;
  logic [3:0]          r_d_streak;
  logic [7:0]          r_tmo;
  logic                r_i_valid;
  logic                r_d_valid;
  logic                r_err;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [WORD_LEN-1:0] r_mem_addr;
  logic [WORD_LEN-1:0] r_mem_wdata;
  logic [WORD_LEN-1:0] r_i_rdata;
  logic [WORD_LEN-1:0] r_d_rdata;
  logic                w_pick_d;

  // D wins unless fetch is also waiting and has already been passed over MAX_D_STREAK times
  assign w_pick_d = d_req & (~i_req | (r_d_streak != MAX_S));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= 1'b0;
      r_d_streak  <= '0;
      r_tmo       <= '0;
      r_i_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req | d_req) begin
            r_state   <= BUSY;
            r_mem_req <= 1'b1;
            r_tmo     <= '0;
            r_gnt     <= w_pick_d;
            if (w_pick_d) begin
              r_mem_addr  <= d_addr;
              r_mem_we    <= d_we;
              r_mem_wdata <= d_we ? d_wdata : '0;
              if (!i_req)
                r_d_streak <= '0;
              else if (r_d_streak != MAX_S)
                r_d_streak <= r_d_streak + 4'd1;
            end else begin
              r_mem_addr  <= i_addr;
              r_mem_we    <= 1'b0;
              r_mem_wdata <= '0;
              r_d_streak  <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (!r_mem_we) begin
              if (r_gnt) r_d_rdata <= mem_rdata;
              else       r_i_rdata <= mem_rdata;
            end
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_i_valid   <= ~r_gnt;
            r_d_valid   <= r_gnt;
            r_state     <= DONE;
          end else if (r_tmo == TMO_LAST) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_i_valid <= ~r_gnt;
            r_d_valid <= r_gnt;
            r_state   <= DONE;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_valid   = r_i_valid;
  assign d_valid   = r_d_valid;
  assign err       = r_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_stall   = i_req & ~r_i_valid;
  assign d_stall   = d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: drivers push expected completions, a negedge monitor pops and compares them.
// Memory map of the bench: bit 8 set = data region, bit 12 set = dead region (memory never acks).
module tb_mem_arbiter;
  localparam int W    = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, d_req, d_we;
  logic [W-1:0] i_addr, d_addr, d_wdata;
  logic [W-1:0] i_rdata, d_rdata;
  logic         i_valid, d_valid, i_stall, d_stall, err;
  logic         mem_req, mem_we, mem_ack;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.WORD_LEN(W), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] addr;
    logic         we;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic         err;
  } exp_t;

  exp_t         iq[$];
  exp_t         dq[$];
  int           grant_log[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] ref_dmem [16];
  logic [W-1:0] phys_dmem[16];
  logic [W-1:0] ref_i_last = '0;
  logic [W-1:0] ref_d_last = '0;
  int           force_wait = -1;
  int           spur_req = 0;
  int           streak_ref = 0;
  logic         ip_s = 1'b0, dp_s = 1'b0, prev_mem_req = 1'b0;
  logic [W-1:0] g_addr, g_wdata;
  logic         g_we;

  function automatic logic [W-1:0] rom(input logic [W-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic dead(input logic [W-1:0] a);
    return a[12];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one access and record the completion the memory map implies
  task automatic issue(input logic side, input logic [W-1:0] a, input logic we, input logic [W-1:0] wd);
    exp_t e;
    e.addr  = a;
    e.we    = side & we;
    e.wdata = (side & we) ? wd : '0;
    e.err   = dead(a);
    if (!side) begin
      if (!e.err) ref_i_last = rom(a);
      e.rdata = ref_i_last;
      iq.push_back(e);
      i_addr = a;
      i_req  = 1'b1;
    end else begin
      if (!e.err) begin
        if (we) ref_dmem[a[5:2]] = wd;
        else    ref_d_last = ref_dmem[a[5:2]];
      end
      e.rdata = ref_d_last;
      dq.push_back(e);
      d_addr  = a;
      d_we    = we;
      d_wdata = wd;
      d_req   = 1'b1;
    end
  endtask

  task automatic wait_done(input logic side, output int busy);
    int c;
    busy = 0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (mem_req) busy++;
    end while (!(side ? d_valid : i_valid) && c < 200);
    checks++;
    if (!(side ? d_valid : i_valid)) begin
      errors++;
      $display("FAIL %s_complete: no valid after %0d cycles", side ? "d" : "i", c);
    end
    @(posedge clk); #1;
  endtask

  task automatic drop(input logic side);
    if (side) d_req = 1'b0;
    else      i_req = 1'b0;
  endtask

  task automatic run_side(input logic side, input int n, input logic rnd);
    int b;
    for (int k = 0; k < n; k++) begin
      logic [W-1:0] a;
      logic         we;
      a = (side ? 32'h100 : 32'h0) | ($urandom_range(0, 15) << 2);
      if (rnd && $urandom_range(0, 7) == 0) a = a | 32'h1000;
      we = side && ($urandom_range(0, 1) == 1);
      issue(side, a, we, $urandom);
      wait_done(side, b);
      if (rnd && $urandom_range(0, 2) == 0) begin
        drop(side);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drop(side);
  endtask

  // Behavioural memory: random or forced wait states, dead region never acks
  initial begin : mem_model
    int   wl;
    int   spur_seen;
    logic active;
    wl = 0; spur_seen = 0; active = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!mem_req) begin
        active = 1'b0;
        if (spur_req != spur_seen) begin
          spur_seen = spur_req;
          mem_ack   = 1'b1;
          mem_rdata = 32'hBAD0BAD0;
        end
      end else begin
        if (!active) begin
          active = 1'b1;
          wl = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        end
        if (!dead(mem_addr)) begin
          if (wl == 0) begin
            mem_ack = 1'b1;
            if (mem_we) begin
              phys_dmem[mem_addr[5:2]] = mem_wdata;
              mem_rdata = $urandom;
            end else begin
              mem_rdata = mem_addr[8] ? phys_dmem[mem_addr[5:2]] : rom(mem_addr);
            end
          end else begin
            wl--;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    ip_s <= i_req;
    dp_s <= d_req;
  end

  // Monitor: completions, stalls, grant choice and request stability
  always @(negedge clk) begin
    exp_t e;
    int   exp_side;
    if (rst) begin
      prev_mem_req = 1'b0;
      streak_ref   = 0;
    end else begin
      chk("i_stall", 32'(i_stall), 32'(i_req & ~i_valid));
      chk("d_stall", 32'(d_stall), 32'(d_req & ~d_valid));
      chk("valid_overlap", 32'(i_valid & d_valid), 32'd0);
      if (!i_valid && !d_valid) chk("err_idle", 32'(err), 32'd0);
      if (i_valid) begin
        if (iq.size() == 0) chk("i_unexpected_valid", 32'(i_valid), 32'd0);
        else begin
          e = iq.pop_front();
          chk("i_rdata", i_rdata, e.rdata);
          chk("i_err", 32'(err), 32'(e.err));
        end
      end
      if (d_valid) begin
        if (dq.size() == 0) chk("d_unexpected_valid", 32'(d_valid), 32'd0);
        else begin
          e = dq.pop_front();
          chk("d_rdata", d_rdata, e.rdata);
          chk("d_err", 32'(err), 32'(e.err));
        end
      end
      if (mem_req && !prev_mem_req) begin
        if (ip_s && dp_s) exp_side = (streak_ref == MAXS) ? 0 : 1;
        else              exp_side = dp_s ? 1 : 0;
        if (exp_side == 1) streak_ref = ip_s ? ((streak_ref < MAXS) ? streak_ref + 1 : MAXS) : 0;
        else               streak_ref = 0;
        chk("grant_side", 32'(mem_addr[8]), 32'(exp_side));
        grant_log.push_back(int'(mem_addr[8]));
        if (mem_addr[8] ? dq.size() == 0 : iq.size() == 0) chk("grant_without_request", 32'(mem_req), 32'd0);
        else begin
          e = mem_addr[8] ? dq[0] : iq[0];
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_wdata", mem_wdata, e.wdata);
        end
        g_addr = mem_addr; g_we = mem_we; g_wdata = mem_wdata;
      end else if (mem_req) begin
        chk("busy_addr_stable", mem_addr, g_addr);
        chk("busy_we_stable", 32'(mem_we), 32'(g_we));
        chk("busy_wdata_stable", mem_wdata, g_wdata);
      end
      prev_mem_req = mem_req;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b;
    int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int k = 0; k < 16; k++) begin
      ref_dmem[k]  = 32'(k) * 32'h01010101;
      phys_dmem[k] = 32'(k) * 32'h01010101;
    end
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    rst = 1'b1;
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_valids_err", {29'd0, i_valid, d_valid, err}, 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait fetch of 0x10
    force_wait = 0;
    issue(1'b0, 32'h10, 1'b0, '0);
    wait_done(1'b0, b);
    drop(1'b0);
    chk("i_zero_wait_busy", 32'(b), 32'd1);
    repeat (2) @(posedge clk); #1;

    // Both sides saturating the port
    grant_log.delete();
    fork
      run_side(1'b1, 8, 1'b0);
      run_side(1'b0, 2, 1'b0);
    join
    if (grant_log.size() < 10) chk("order_len", 32'(grant_log.size()), 32'd10);
    else for (int k = 0; k < 10; k++) chk($sformatf("order_%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));
    repeat (2) @(posedge clk); #1;

    // D write with 3 wait states
    force_wait = 3;
    issue(1'b1, 32'h140, 1'b1, 32'h12345678);
    wait_done(1'b1, b);
    drop(1'b1);
    chk("d_write_busy", 32'(b), 32'd4);

    // Timeout on a dead address, then a normal read
    force_wait = 0;
    issue(1'b1, 32'h1104, 1'b0, 32'hFFFF0000);
    wait_done(1'b1, b);
    drop(1'b1);
    chk("timeout_busy", 32'(b), 32'(TMO));
    issue(1'b1, 32'h104, 1'b0, '0);
    wait_done(1'b1, b);
    drop(1'b1);
    chk("after_timeout_busy", 32'(b), 32'd1);

    // Spurious ack while idle
    repeat (2) @(posedge clk); #1;
    spur_req++;
    repeat (4) begin
      @(negedge clk);
      chk("spur_mem_req", 32'(mem_req), 32'd0);
    end
    chk("spur_i_rdata", i_rdata, ref_i_last);
    chk("spur_d_rdata", d_rdata, ref_d_last);

    // Asynchronous reset in the second BUSY cycle
    @(posedge clk); #1;
    issue(1'b1, 32'h1100, 1'b0, '0);
    b = 0;
    do begin @(negedge clk); b++; end while (!mem_req && b < 20);
    chk("rst_test_grant", 32'(mem_req), 32'd1);
    @(posedge clk); #2;
    issue(1'b0, 32'h20, 1'b0, '0);
    rst = 1'b1;
    #1;
    chk("midbusy_mem_req", 32'(mem_req), 32'd0);
    chk("midbusy_valids", {30'd0, i_valid, d_valid}, 32'd0);
    d_req = 1'b0;
    dq.delete();
    ref_i_last = rom(32'h20);
    ref_d_last = '0;
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_grant", 32'(mem_req), 32'd1);
    chk("post_rst_addr", mem_addr, 32'h20);
    wait_done(1'b0, b);
    drop(1'b0);

    // Randomised traffic with gaps, waits and dead addresses
    force_wait = -1;
    repeat (2) @(posedge clk); #1;
    fork
      run_side(1'b0, 40, 1'b1);
      run_side(1'b1, 60, 1'b1);
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
